func_sweep_ctrl: RTL and testbench

Self-checking sweep controller for a small combinational function block under test. On `start` it steps the function's inputs through every combination in ascending binary order. It waits a programmable settle time, samples the function output and compares it against a caller-supplied expected truth table. It reports captured table, mismatch count, first failing index, and pass/fail. It replaces hand-written stimulus sequences in function-level benches and is reusable as an on-chip built-in self-test sequencer.

---
 rtl/func_sweep_ctrl.sv | 168 ++++++++++++++++
 tb/tb_func_sweep_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/func_sweep_ctrl.sv
// Sweep controller that drives every input combination of a small combinational block,
// samples its output after a settle time and compares it against a latched truth table.
module func_sweep_ctrl #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [2**N_IN-1:0]   expected,
    input  logic                 dut_out,
    output logic [N_IN-1:0]      dut_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2**N_IN-1:0]   captured,
    output logic [N_IN:0]        mismatch_cnt,
    output logic                 fail_valid,
    output logic [N_IN-1:0]      first_fail_idx
);

    localparam int NV = 2**N_IN;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [N_IN-1:0] IDX_LAST = N_IN'(NV - 1);
    localparam logic [N_IN-1:0] IDX_ONE  = N_IN'(1);
    localparam logic [N_IN:0]   MIS_ONE  = (N_IN + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              state_r, state_s;
    logic [N_IN-1:0]     idx_r, idx_s;
    logic [CW-1:0]       cnt_r, cnt_s;
    logic [NV-1:0]       exp_r, exp_s;
    logic [N_IN-1:0]     dut_in_s;
    logic                busy_s, done_s, pass_s;
    logic [NV-1:0]       captured_s;
    logic [N_IN:0]       mismatch_cnt_s;
    logic                fail_valid_s;
    logic [N_IN-1:0]     first_fail_idx_s;

    // Next-state and next-output logic; every register holds unless a state acts on it.
    always_comb begin
        state_s          = state_r;
        idx_s            = idx_r;
        cnt_s            = cnt_r;
        exp_s            = exp_r;
        dut_in_s         = dut_in;
        pass_s           = pass;
        captured_s       = captured;
        mismatch_cnt_s   = mismatch_cnt;
        fail_valid_s     = fail_valid;
        first_fail_idx_s = first_fail_idx;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    exp_s            = expected;
                    idx_s            = '0;
                    cnt_s            = '0;
                    dut_in_s         = '0;
                    captured_s       = '0;
                    mismatch_cnt_s   = '0;
                    fail_valid_s     = 1'b0;
                    first_fail_idx_s = '0;
                    pass_s           = 1'b0;
                    state_s          = S_SETTLE;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    dut_in_s = '0;
                    pass_s   = 1'b0;
                    state_s  = S_IDLE;
                end else if (cnt_r == CNT_LAST) begin
                    state_s = S_SAMPLE;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            S_SAMPLE: begin
                if (abort) begin
                    dut_in_s = '0;
                    pass_s   = 1'b0;
                    state_s  = S_IDLE;
                end else begin
                    captured_s[idx_r] = dut_out;
                    if (dut_out != exp_r[idx_r]) begin
                        mismatch_cnt_s = mismatch_cnt + MIS_ONE;
                        if (!fail_valid) begin
                            first_fail_idx_s = idx_r;
                            fail_valid_s     = 1'b1;
                        end else begin
                            first_fail_idx_s = first_fail_idx;
                        end
                    end else begin
                        mismatch_cnt_s = mismatch_cnt;
                    end
                    // Verdict is registered on entry to DONE so it appears together with done.
                    if (idx_r == IDX_LAST) begin
                        pass_s  = ~|mismatch_cnt_s;
                        state_s = S_DONE;
                    end else begin
                        idx_s    = idx_r + IDX_ONE;
                        dut_in_s = idx_r + IDX_ONE;
                        cnt_s    = '0;
                        state_s  = S_SETTLE;
                    end
                end
            end
            S_DONE: begin
                if (abort) begin
                    dut_in_s = '0;
                    pass_s   = 1'b0;
                end else begin
                    pass_s = pass;
                end
                state_s = S_IDLE;
            end
            default: begin
                dut_in_s = '0;
                state_s  = S_IDLE;
            end
        endcase
        busy_s = (state_s == S_SETTLE) || (state_s == S_SAMPLE);
        done_s = (state_s == S_DONE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r        <= S_IDLE;
            idx_r          <= '0;
            cnt_r          <= '0;
            exp_r          <= '0;
            dut_in         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            captured       <= '0;
            mismatch_cnt   <= '0;
            fail_valid     <= 1'b0;
            first_fail_idx <= '0;
        end else begin
            state_r        <= state_s;
            idx_r          <= idx_s;
            cnt_r          <= cnt_s;
            exp_r          <= exp_s;
            dut_in         <= dut_in_s;
            busy           <= busy_s;
            done           <= done_s;
            pass           <= pass_s;
            captured       <= captured_s;
            mismatch_cnt   <= mismatch_cnt_s;
            fail_valid     <= fail_valid_s;
            first_fail_idx <= first_fail_idx_s;
        end
    end

endmodule

// File: tb/tb_func_sweep_ctrl.sv
// Directed bench for func_sweep_ctrl: a 2-input/settle-2 instance and a 3-input/settle-1
// instance, each driving a bench-side reference function selected per vector.
module tb_func_sweep_ctrl;

    localparam int FN_AND = 0;
    localparam int FN_XOR = 1;
    localparam int FN_OR  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start_a, start_b, abort_a, abort_b;
    logic [3:0] exp_a;
    logic [7:0] exp_b;
    int         fn_sel;

    logic [1:0] din_a;
    logic [2:0] din_b;
    logic       dout_a, dout_b;
    logic       busy_a, done_a, pass_a, fv_a;
    logic       busy_b, done_b, pass_b, fv_b;
    logic [3:0] cap_a;
    logic [7:0] cap_b;
    logic [2:0] mis_a;
    logic [3:0] mis_b;
    logic [1:0] ffi_a;
    logic [2:0] ffi_b;

    int passed = 0;
    int total  = 0;

    function automatic logic fref(input int fn, input logic [2:0] v, input int n);
        logic a, o, x;
        a = 1'b1; o = 1'b0; x = 1'b0;
        for (int i = 0; i < n; i++) begin
            a = a & v[i];
            o = o | v[i];
            x = x ^ v[i];
        end
        return (fn == FN_AND) ? a : (fn == FN_XOR) ? x : o;
    endfunction

    assign dout_a = fref(fn_sel, {1'b0, din_a}, 2);
    assign dout_b = fref(fn_sel, din_b, 3);

    func_sweep_ctrl #(.N_IN(2), .SETTLE(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .expected(exp_a),
        .dut_out(dout_a), .dut_in(din_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .captured(cap_a), .mismatch_cnt(mis_a), .fail_valid(fv_a), .first_fail_idx(ffi_a)
    );

    func_sweep_ctrl #(.N_IN(3), .SETTLE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .expected(exp_b),
        .dut_out(dout_b), .dut_in(din_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .captured(cap_b), .mismatch_cnt(mis_b), .fail_valid(fv_b), .first_fail_idx(ffi_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) $display("FAIL %s: got %0h, want %0h", name, act, req);
        else passed++;
    endtask

    function automatic int o_din(input bit sel);  return sel ? int'(din_b) : int'(din_a); endfunction
    function automatic bit o_busy(input bit sel); return sel ? busy_b : busy_a; endfunction
    function automatic bit o_done(input bit sel); return sel ? done_b : done_a; endfunction
    function automatic bit o_pass(input bit sel); return sel ? pass_b : pass_a; endfunction
    function automatic bit o_fv(input bit sel);   return sel ? fv_b : fv_a; endfunction
    function automatic int o_mis(input bit sel);  return sel ? int'(mis_b) : int'(mis_a); endfunction
    function automatic int o_ffi(input bit sel);  return sel ? int'(ffi_b) : int'(ffi_a); endfunction
    function automatic logic [7:0] o_cap(input bit sel);
        return sel ? cap_b : {4'b0000, cap_a};
    endfunction

    task automatic set_start(input bit sel, input logic v);
        if (sel) start_b = v; else start_a = v;
    endtask

    task automatic set_exp(input bit sel, input logic [7:0] v);
        if (sel) exp_b = v; else exp_a = v[3:0];
    endtask

    // Full sweep: checks dut_in/busy per cycle, a single done pulse at the predicted edge,
    // and scrambles `expected` after acceptance. Returns one cycle after DONE (back in IDLE).
    task automatic sweep(input bit sel, input int fn, input logic [7:0] ex, input bit spam,
                         input string tag);
        int per, nv, last, dcnt, dedge, vexp;
        bit ok;
        per = sel ? 2 : 3;
        nv  = sel ? 8 : 4;
        last = nv * per;
        fn_sel = fn;
        set_exp(sel, ex);
        set_start(sel, 1'b1);
        @(negedge clk);
        set_start(sel, spam);
        set_exp(sel, ~ex);
        ok = (o_din(sel) == 0) && o_busy(sel) && !o_done(sel);
        dcnt = 0;
        dedge = -1;
        for (int e = 1; e <= last + 1; e++) begin
            @(negedge clk);
            vexp = e / per;
            if (vexp > nv - 1) vexp = nv - 1;
            if (o_din(sel) != vexp || o_busy(sel) != (e < last)) ok = 1'b0;
            if (o_done(sel)) begin
                dcnt++;
                dedge = e;
            end
        end
        chk({tag, " dut_in/busy sequence"}, 32'(ok), 32'd1);
        chk({tag, " done pulse count"}, dcnt, 32'd1);
        chk({tag, " done edge"}, dedge, last);
    endtask

    typedef struct {
        bit         sel;
        int         fn;
        logic [7:0] ex;
        logic [7:0] cap;
        int         mis;
        bit         fv;
        int         ffi;
        bit         pass;
        string      tag;
    } vec_t;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{1'b0, FN_AND, 8'h08, 8'h08, 0, 1'b0, 0, 1'b1, "a_and_pass"};
        tbl[1] = '{1'b0, FN_XOR, 8'h08, 8'h06, 3, 1'b1, 1, 1'b0, "a_xor_fail"};
        tbl[2] = '{1'b0, FN_OR,  8'h08, 8'h0E, 2, 1'b1, 1, 1'b0, "a_or_fail"};
        tbl[3] = '{1'b0, FN_AND, 8'h07, 8'h08, 4, 1'b1, 0, 1'b0, "a_all_fail"};
        tbl[4] = '{1'b0, FN_XOR, 8'h06, 8'h06, 0, 1'b0, 0, 1'b1, "a_xor_pass"};
        tbl[5] = '{1'b1, FN_OR,  8'hFE, 8'hFE, 0, 1'b0, 0, 1'b1, "b_or_pass"};
        tbl[6] = '{1'b1, FN_XOR, 8'h96, 8'h96, 0, 1'b0, 0, 1'b1, "b_xor_pass"};
        tbl[7] = '{1'b1, FN_AND, 8'h00, 8'h80, 1, 1'b1, 7, 1'b0, "b_and_lastfail"};

        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; abort_a = 1'b0; abort_b = 1'b0;
        exp_a = 4'h0; exp_b = 8'h00; fn_sel = FN_AND;
        repeat (2) @(negedge clk);
        chk("reset busy/done/pass/fv a", {busy_a, done_a, pass_a, fv_a}, 4'h0);
        chk("reset din/cap/mis/ffi a", {din_a, cap_a, mis_a, ffi_a}, 11'h0);
        chk("reset busy/done/pass b", {busy_b, done_b, pass_b, fv_b, cap_b, mis_b}, 16'h0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            sweep(tbl[i].sel, tbl[i].fn, tbl[i].ex, 1'b0, tbl[i].tag);
            chk({tbl[i].tag, " captured"}, o_cap(tbl[i].sel), tbl[i].cap);
            chk({tbl[i].tag, " mismatch_cnt"}, o_mis(tbl[i].sel), tbl[i].mis);
            chk({tbl[i].tag, " fail_valid"}, 32'(o_fv(tbl[i].sel)), 32'(tbl[i].fv));
            chk({tbl[i].tag, " first_fail_idx"}, o_ffi(tbl[i].sel), tbl[i].ffi);
            chk({tbl[i].tag, " pass"}, 32'(o_pass(tbl[i].sel)), 32'(tbl[i].pass));
            @(negedge clk);
        end

        // Reset in the middle of a failing sweep: edge 5 counted from acceptance.
        fn_sel = FN_XOR; exp_a = 4'hF; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre-reset partial mismatch", {fv_a, mis_a}, 4'b1001);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid-sweep reset outputs", {busy_a, done_a, pass_a, fv_a, din_a, cap_a, mis_a, ffi_a},
            15'h0);
        sweep(1'b0, FN_AND, 8'h08, 1'b0, "post_reset");
        chk("post_reset pass", 32'(pass_a), 32'd1);
        @(negedge clk);

        // Abort at edge 7 of an OR sweep: vectors 0 and 1 already sampled.
        fn_sel = FN_OR; exp_a = 4'hE; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (6) @(negedge clk);
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        chk("abort busy/dut_in/pass", {busy_a, din_a, pass_a}, 4'h0);
        chk("abort partial captured", cap_a, 4'b0010);
        begin
            int dseen;
            dseen = 0;
            for (int c = 0; c < 16; c++) begin
                @(negedge clk);
                if (done_a) dseen++;
            end
            chk("abort no done", dseen, 32'd0);
        end
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        chk("abort in idle no effect", {busy_a, cap_a}, 5'b00010);

        // Abort and start together in IDLE: start wins.
        start_a = 1'b1; abort_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; abort_a = 1'b0;
        chk("start beats abort", {busy_a, cap_a}, 5'b10000);
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        chk("abort in settle", busy_a, 1'b0);

        // start held high throughout: no restart mid-sweep, new sweep right after DONE.
        sweep(1'b0, FN_AND, 8'h08, 1'b1, "spam");
        chk("spam captured", cap_a, 4'h8);
        @(negedge clk);
        start_a = 1'b0;
        chk("held start restarts", {busy_a, din_a, cap_a, pass_a}, 8'b1000_0000);
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
